banco_de_registradores: RTL and testbench
=========================================

Name: banco_de_registradores

Overview:
- General-purpose register file of the processor: 32 × 32-bit registers.
- Two combinational read ports, plus a third read port (JR) for jump/shift targets.
- Primary write port from the ALU, memory or input path; secondary write port for the ALU's second result.
- Also holds the compare flag (CM), the data-stack pointer (SP) and the call-stack pointer (AS).
- Sits between the control unit, the ALU and the data/stack memories.

Parameters:
- NREG, 32, number of registers (address width 5)
- WIDTH, 32, register width
- SP_INIT, 32'h0000_3FFC, reset value of SP (top of the 16 KB data memory)
- SP_IDX, 29, register index aliased to SP
- RF_IDX, 31, register index written by the secondary port, also output on RF

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- RL0  in  5  read address, port 0
- RL1  in  5  read address, port 1
- RE0  in  5  primary write address; also JR read address
- esc0  in  32  primary write data
- esc1  in  32  secondary write data (ALU s1)
- comp  in  1  ALU compare result
- D0  out  32  R[RL0]
- D1  out  32  R[RL1]
- CM  out  1  registered compare flag
- AS  out  32  call-stack pointer (next free slot)
- SP  out  32  data-stack pointer (= R[SP_IDX])
- JR  out  32  R[RE0]
- RF  out  32  R[RF_IDX]
- ctrl  in  8  bit0 EscReg1, bit1 EscReg2, bit2 Pilha1, bit3 Pilha2, bit4 EmpDesemp, bits7:5 instruction class

Behaviour:
- Reads: D0, D1, JR, RF, SP are combinational. R0 always reads 0.
- Read during write returns the old value; the new value is visible after the edge.
- rst (async):
  - all registers cleared to 0, except R[SP_IDX] = SP_INIT
  - AS = 0, CM = 0
  - rst held high blocks all writes
- Primary write, on posedge: if EscReg1 and RE0 != 0, then R[RE0] <= esc0.
- Secondary write, on posedge: if EscReg2, then R[RF_IDX] <= esc1.
- Both write ports targeting RF_IDX in the same cycle: the primary write wins.
- Data stack, on posedge when Pilha2:
  - EmpDesemp = 1 (push): SP <= SP + 4
  - EmpDesemp = 0 (pop): SP <= SP − 4
  - The external memory uses SP for the store address and SP − 4 for the load address, both from the pre-edge value.
  - If EscReg1 targets SP_IDX in the same cycle, the primary write wins over the adjustment.
  - A pop with EscReg1 set writes the popped data to R[RE0] in the same cycle.
- Call stack, on posedge when Pilha1:
  - EmpDesemp = 1 (call): AS <= AS + 1
  - EmpDesemp = 0 (return): AS <= AS − 1
  - AS is 32-bit and wraps modulo 2^32. Popping at AS = 0 gives 32'hFFFF_FFFF; no error is flagged.
- Pilha1 and Pilha2 together: both pointers update independently.
- CM: loaded from comp on every rising edge. It therefore reflects the previous instruction's compare and is stable for the branch decision in the following cycle.
- ctrl[7:5]: carried for decode only; no effect inside this block.
- SP arithmetic wraps modulo 2^32.

Decomposition:
- Shared package holds:
  - ctrl bit indices: ESC_REG1 = 0, ESC_REG2 = 1, PILHA1 = 2, PILHA2 = 3, EMP_DESEMP = 4
  - CLASS_LSB = 5
  - SP_IDX, RF_IDX, SP_INIT
- One natural sub-module, stack_pointer_unit: SP/AS increment/decrement and the write-priority mux. The register array stays in the top level.

Test Plan:
- Reset: assert rst mid-cycle → immediately D0 = D1 = JR = 0, SP = 32'h3FFC, AS = 0, CM = 0. Writes issued during reset are ignored.
- Write/read R5: RE0 = 5, esc0 = 32'hDEADBEEF, EscReg1 = 1, one edge, then RL0 = RL1 = 5 → D0 = D1 = 32'hDEADBEEF, and JR = 32'hDEADBEEF while RE0 = 5.
- R0 protection: EscReg1 with RE0 = 0, esc0 = 32'h1234 → D0 (RL0 = 0) stays 0.
- Dual write: EscReg1 (RE0 = 3, esc0 = 7) plus EscReg2 (esc1 = 9) → R3 = 7, RF = 9. Repeat with RE0 = 31, esc0 = 5 → RF = 5.
- Stacks: from reset, two Pilha2 pushes → SP = 32'h4004; one pop → SP = 32'h4000. Pilha1 call, call, return → AS = 1. Return at AS = 0 → AS = 32'hFFFFFFFF.
- CM timing: comp = 1 for one cycle → CM goes 1 after that edge and back to 0 one edge after comp drops.

Source files
------------

// File: rtl/banco_de_registradores_pkg.sv
// Shared constants for the general-purpose register file.
// Control-word bit positions, aliased register indices and reset values.
package banco_de_registradores_pkg;

    localparam int NREG  = 32;
    localparam int WIDTH = 32;

    localparam int SP_IDX = 29;
    localparam int RF_IDX = 31;

    localparam logic [WIDTH-1:0] SP_INIT = 32'h0000_3FFC;

    localparam int ESC_REG1   = 0;
    localparam int ESC_REG2   = 1;
    localparam int PILHA1     = 2;
    localparam int PILHA2     = 3;
    localparam int EMP_DESEMP = 4;
    localparam int CLASS_LSB  = 5;

endpackage

// File: rtl/banco_de_registradores_if.sv
// Bus between the control unit / ALU and the register file.
// master drives addresses, data and control; slave returns the reads.
import banco_de_registradores_pkg::*;

interface banco_de_registradores_if;
    logic [4:0]       RL0;
    logic [4:0]       RL1;
    logic [4:0]       RE0;
    logic [WIDTH-1:0] esc0;
    logic [WIDTH-1:0] esc1;
    logic             comp;
    logic [7:0]       ctrl;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic             CM;
    logic [WIDTH-1:0] AS;
    logic [WIDTH-1:0] SP;
    logic [WIDTH-1:0] JR;
    logic [WIDTH-1:0] RF;

    modport master (
        output RL0, RL1, RE0, esc0, esc1, comp, ctrl,
        input  D0, D1, CM, AS, SP, JR, RF
    );

    modport slave (
        input  RL0, RL1, RE0, esc0, esc1, comp, ctrl,
        output D0, D1, CM, AS, SP, JR, RF
    );
endinterface

// File: rtl/banco_de_registradores_stack_pointer_unit.sv
// Data-stack and call-stack pointer arithmetic.
// Produces the next SP value (primary write beats push/pop) and holds AS.
import banco_de_registradores_pkg::*;

module stack_pointer_unit (
    input  logic             clk,
    input  logic             rst,
    input  logic             we0,
    input  logic             pilha1,
    input  logic             pilha2,
    input  logic             emp,
    input  logic [4:0]       re0,
    input  logic [WIDTH-1:0] esc0,
    input  logic [WIDTH-1:0] sp_q,
    output logic             sp_en,
    output logic [WIDTH-1:0] sp_d,
    output logic [WIDTH-1:0] as_q
);

    logic sp_hit;

    assign sp_hit = we0 && (re0 == 5'(SP_IDX));

    // SP update: an explicit register write overrides the stack adjustment
    always_comb begin
        sp_en = sp_hit || pilha2;
        sp_d  = sp_q;
        if (sp_hit)
            sp_d = esc0;
        else if (pilha2)
            sp_d = emp ? sp_q + 32'd4 : sp_q - 32'd4;
    end

    // Call-stack pointer: call increments, return decrements, wraps freely
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            as_q <= '0;
        else if (pilha1)
            as_q <= emp ? as_q + 32'd1 : as_q - 32'd1;
    end

endmodule

// File: rtl/banco_de_registradores.sv
// 32 x 32-bit register file with three read ports, two write ports,
// compare flag and stack pointers (SP aliased to R29, AS separate).
import banco_de_registradores_pkg::*;

module banco_de_registradores (
    input logic                        clk,
    input logic                        rst,
    banco_de_registradores_if.slave    bus
);

    logic [WIDTH-1:0] regs [NREG];
    logic             we0;
    logic             we1;
    logic             sp_en;
    logic [WIDTH-1:0] sp_d;
    logic [WIDTH-1:0] as_q;
    logic             cm_q;
    logic             unused_class;

    assign we0 = bus.ctrl[ESC_REG1];
    assign we1 = bus.ctrl[ESC_REG2];

    // Instruction class bits are decoded elsewhere
    assign unused_class = ^bus.ctrl[7:CLASS_LSB];

    stack_pointer_unit u_spu (
        .clk    (clk),
        .rst    (rst),
        .we0    (we0),
        .pilha1 (bus.ctrl[PILHA1]),
        .pilha2 (bus.ctrl[PILHA2]),
        .emp    (bus.ctrl[EMP_DESEMP]),
        .re0    (bus.RE0),
        .esc0   (bus.esc0),
        .sp_q   (regs[SP_IDX]),
        .sp_en  (sp_en),
        .sp_d   (sp_d),
        .as_q   (as_q)
    );

    // Register array: secondary write first so a primary write to RF_IDX wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
        end else begin
            if (we1)
                regs[RF_IDX] <= bus.esc1;
            if (we0 && bus.RE0 != 5'd0 && bus.RE0 != 5'(SP_IDX))
                regs[bus.RE0] <= bus.esc0;
            if (sp_en)
                regs[SP_IDX] <= sp_d;
        end
    end

    // Compare flag: holds last cycle's ALU compare for the branch decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cm_q <= 1'b0;
        else
            cm_q <= bus.comp;
    end

    assign bus.D0 = (bus.RL0 == 5'd0) ? '0 : regs[bus.RL0];
    assign bus.D1 = (bus.RL1 == 5'd0) ? '0 : regs[bus.RL1];
    assign bus.JR = (bus.RE0 == 5'd0) ? '0 : regs[bus.RE0];
    assign bus.RF = regs[RF_IDX];
    assign bus.SP = regs[SP_IDX];
    assign bus.AS = as_q;
    assign bus.CM = cm_q;

endmodule

// File: tb/tb_banco_de_registradores.sv
// Scoreboard bench for banco_de_registradores: stimulus queues expected
// values, a negedge monitor pops and compares them against the outputs.
module tb_banco_de_registradores;

    localparam int S_D0 = 0;
    localparam int S_D1 = 1;
    localparam int S_JR = 2;
    localparam int S_RF = 3;
    localparam int S_SP = 4;
    localparam int S_AS = 5;
    localparam int S_CM = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;

    banco_de_registradores_if bus ();

    banco_de_registradores dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        q[$];
    exp_t        e;
    logic [31:0] act;
    int          n_vec;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int s);
        case (s)
            S_D0:    return bus.D0;
            S_D1:    return bus.D1;
            S_JR:    return bus.JR;
            S_RF:    return bus.RF;
            S_SP:    return bus.SP;
            S_AS:    return bus.AS;
            default: return {31'd0, bus.CM};
        endcase
    endfunction

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = pick(e.sel);
            n_vec++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.val);
            end
        end
    end

    task automatic cyc(input logic [4:0] rl0, input logic [4:0] rl1,
                       input logic [4:0] re0, input logic [31:0] e0,
                       input logic [31:0] e1, input logic c,
                       input logic [7:0] ct);
        @(posedge clk);
        #1;
        bus.RL0  = rl0;
        bus.RL1  = rl1;
        bus.RE0  = re0;
        bus.esc0 = e0;
        bus.esc1 = e1;
        bus.comp = c;
        bus.ctrl = ct;
    endtask

    task automatic ex(input string n, input int s, input logic [31:0] v);
        exp_t t;
        t.name = n;
        t.sel  = s;
        t.val  = v;
        q.push_back(t);
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        bus.RL0  = '0;
        bus.RL1  = '0;
        bus.RE0  = '0;
        bus.esc0 = '0;
        bus.esc1 = '0;
        bus.comp = 1'b0;
        bus.ctrl = '0;

        // Reset asserted mid-cycle while writes/stack ops/comp are requested
        cyc(5, 29, 5, 32'hAAAA_AAAA, 32'h5555_5555, 1, 8'h1D);
        rst = 1'b1;
        ex("rst_d0", S_D0, 32'h0);
        ex("rst_d1_sp", S_D1, 32'h3FFC);
        ex("rst_jr", S_JR, 32'h0);
        ex("rst_sp", S_SP, 32'h3FFC);
        ex("rst_as", S_AS, 32'h0);
        ex("rst_cm", S_CM, 32'h0);
        ex("rst_rf", S_RF, 32'h0);
        cyc(5, 29, 5, 32'hAAAA_AAAA, 32'h5555_5555, 1, 8'h1D);
        ex("rsthold_d0", S_D0, 32'h0);
        ex("rsthold_sp", S_SP, 32'h3FFC);
        ex("rsthold_as", S_AS, 32'h0);
        ex("rsthold_cm", S_CM, 32'h0);
        ex("rsthold_rf", S_RF, 32'h0);

        cyc(5, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b0;
        ex("post_rst_d0", S_D0, 32'h0);
        ex("post_rst_as", S_AS, 32'h0);

        // Write R5 and read back; read-during-write shows the old value
        cyc(5, 0, 5, 32'hDEAD_BEEF, 0, 0, 8'h01);
        ex("rdw_old", S_D0, 32'h0);
        cyc(5, 5, 5, 0, 0, 0, 8'h00);
        ex("r5_d0", S_D0, 32'hDEAD_BEEF);
        ex("r5_d1", S_D1, 32'hDEAD_BEEF);
        ex("r5_jr", S_JR, 32'hDEAD_BEEF);

        // R0 is never written
        cyc(0, 0, 0, 32'h1234, 0, 0, 8'h01);
        ex("r0_wr_d0", S_D0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        ex("r0_d0", S_D0, 32'h0);
        ex("r0_jr", S_JR, 32'h0);

        // Dual write to distinct registers
        cyc(0, 0, 3, 32'd7, 32'd9, 0, 8'h03);
        ex("dual_rf_old", S_RF, 32'h0);
        cyc(3, 0, 0, 0, 0, 0, 8'h00);
        ex("dual_r3", S_D0, 32'd7);
        ex("dual_rf", S_RF, 32'd9);

        // Dual write both to R31: primary wins
        cyc(0, 0, 31, 32'd5, 32'd9, 0, 8'h03);
        cyc(0, 31, 0, 0, 0, 0, 8'h00);
        ex("prio_rf", S_RF, 32'd5);
        ex("prio_d1", S_D1, 32'd5);

        // Data stack: push, push, pop, pop-with-write, push overridden
        cyc(0, 0, 0, 0, 0, 0, 8'h18);
        ex("sp_start", S_SP, 32'h3FFC);
        cyc(0, 0, 0, 0, 0, 0, 8'h18);
        ex("sp_push1", S_SP, 32'h4000);
        cyc(0, 0, 0, 0, 0, 0, 8'h08);
        ex("sp_push2", S_SP, 32'h4004);
        cyc(29, 0, 7, 32'hCAFE_F00D, 0, 0, 8'h09);
        ex("sp_pop", S_SP, 32'h4000);
        ex("sp_r29", S_D0, 32'h4000);
        cyc(7, 0, 29, 32'h1000, 0, 0, 8'h19);
        ex("sp_pop2", S_SP, 32'h3FFC);
        ex("pop_wr_r7", S_D0, 32'hCAFE_F00D);

        // Call stack, including underflow wrap
        cyc(0, 0, 0, 0, 0, 0, 8'h14);
        ex("sp_wr_prio", S_SP, 32'h1000);
        ex("as_0", S_AS, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 8'h14);
        ex("as_call1", S_AS, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 8'h04);
        ex("as_call2", S_AS, 32'h2);
        cyc(0, 0, 0, 0, 0, 0, 8'h04);
        ex("as_ret", S_AS, 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 8'h04);
        ex("as_ret0", S_AS, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 8'h1C);
        ex("as_wrap", S_AS, 32'hFFFF_FFFF);
        ex("sp_before_both", S_SP, 32'h1000);

        // Both stacks together, class bits inert, compare flag timing
        cyc(0, 0, 0, 0, 0, 1, 8'hE0);
        ex("both_as", S_AS, 32'h0);
        ex("both_sp", S_SP, 32'h1004);
        ex("cm_pre", S_CM, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        ex("cm_set", S_CM, 32'h1);
        ex("class_sp", S_SP, 32'h1004);
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        ex("cm_clr", S_CM, 32'h0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
